// File: rtl/comparador_serial.sv
// Bit-serial magnitude comparator: A vs B streamed MSB first.
// Optional early exit: define COMPARADOR_SERIAL_EARLY_EXIT_EN.
module comparador_serial #(
    parameter int WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic in_ready,
    output logic done,
    output logic mayor,
    output logic igual,
    output logic menor
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        D_EQ,
        D_GT,
        D_LT
    } dec_t;

    state_t        r_state;
    state_t        w_state_nxt;
    dec_t          r_dec;
    dec_t          w_dec_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic w_xfer;
    logic w_decided_now;

    logic r_ready;
    logic r_done;
    logic r_mayor;
    logic r_igual;
    logic r_menor;
    logic w_ready_nxt;
    logic w_done_nxt;
    logic w_mayor_nxt;
    logic w_igual_nxt;
    logic w_menor_nxt;

    assign w_xfer        = in_valid && (r_state == S_SHIFT);
    assign w_decided_now = (r_dec == D_EQ) && (a_bit != b_bit);

    // State, bit counter and running decision registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dec   <= D_EQ;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dec   <= w_dec_nxt;
        end
    end

    // Next state: first differing bit pair fixes the decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dec_nxt   = r_dec;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_dec_nxt   = D_EQ;
                end
            end
            S_SHIFT: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (w_decided_now) begin
                        w_dec_nxt = a_bit ? D_GT : D_LT;
                    end
                    if (r_cnt == LAST) begin
                        w_state_nxt = S_DONE;
                    end
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
                    if (w_decided_now) begin
                        w_state_nxt = S_DONE;
                    end
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output next values: results clear on start, load entering DONE
    always_comb begin
        w_ready_nxt = (w_state_nxt == S_SHIFT);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_mayor_nxt = r_mayor;
        w_igual_nxt = r_igual;
        w_menor_nxt = r_menor;
        if ((r_state == S_IDLE) && start) begin
            w_mayor_nxt = 1'b0;
            w_igual_nxt = 1'b0;
            w_menor_nxt = 1'b0;
        end else if ((r_state == S_SHIFT) && (w_state_nxt == S_DONE)) begin
            w_mayor_nxt = (w_dec_nxt == D_GT);
            w_igual_nxt = (w_dec_nxt == D_EQ);
            w_menor_nxt = (w_dec_nxt == D_LT);
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_mayor <= 1'b0;
            r_igual <= 1'b0;
            r_menor <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            r_mayor <= w_mayor_nxt;
            r_igual <= w_igual_nxt;
            r_menor <= w_menor_nxt;
        end
    end

    assign in_ready = r_ready;
    assign done     = r_done;
    assign mayor    = r_mayor;
    assign igual    = r_igual;
    assign menor    = r_menor;

endmodule

// File: tb/tb_comparador_serial.sv
// Directed bench for comparador_serial (WIDTH=2 and WIDTH=4 instances).
// Early-exit expectations follow COMPARADOR_SERIAL_EARLY_EXIT_EN.
module tb_comparador_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2, st2, v2, a2, b2;
    logic rdy2, dn2, may2, ig2, men2;
    logic rst4, st4, v4, a4, b4;
    logic rdy4, dn4, may4, ig4, men4;

    int checks = 0;
    int errors = 0;

    comparador_serial #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst2), .start(st2), .in_valid(v2),
        .a_bit(a2), .b_bit(b2), .in_ready(rdy2), .done(dn2),
        .mayor(may2), .igual(ig2), .menor(men2)
    );

    comparador_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(st4), .in_valid(v4),
        .a_bit(a4), .b_bit(b4), .in_ready(rdy4), .done(dn4),
        .mayor(may4), .igual(ig4), .menor(men4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {in_ready, done, mayor, igual, menor}
    function automatic logic [7:0] o2();
        return {3'b0, rdy2, dn2, may2, ig2, men2};
    endfunction

    function automatic logic [7:0] o4();
        return {3'b0, rdy4, dn4, may4, ig4, men4};
    endfunction

    initial begin
        logic [3:0] av;
        logic [3:0] bv;
        rst2 = 1; st2 = 0; v2 = 0; a2 = 0; b2 = 0;
        rst4 = 1; st4 = 0; v4 = 0; a4 = 0; b4 = 0;
        tick();
        tick();
        rst2 = 0; rst4 = 0;
        chk("reset_w2", o2(), 8'h00);
        chk("reset_w4", o4(), 8'h00);
        tick();
        chk("idle_w2", o2(), 8'h00);

        // A=10 B=01, in_valid held high
        st2 = 1; v2 = 1; a2 = 1; b2 = 0;
        tick();
        st2 = 0;
        chk("gt_c1", o2(), 8'h10);
        tick();
        chk("gt_c2", o2(), 8'h10);
        a2 = 0; b2 = 1;
        tick();
        chk("gt_done", o2(), 8'h0C);
        v2 = 0;
        tick();
        chk("gt_hold1", o2(), 8'h04);
        tick();
        chk("gt_hold2", o2(), 8'h04);

        // A=11 B=11
        st2 = 1; v2 = 1; a2 = 1; b2 = 1;
        tick();
        st2 = 0;
        chk("eq_clear", o2(), 8'h10);
        tick();
        chk("eq_shift", o2(), 8'h10);
        tick();
        chk("eq_done", o2(), 8'h0A);
        v2 = 0;
        tick();
        chk("eq_hold", o2(), 8'h02);

        // A=01 B=10, with a stall in the middle
        st2 = 1; v2 = 1; a2 = 0; b2 = 1;
        tick();
        st2 = 0;
        chk("lt_c1", o2(), 8'h10);
        tick();
        chk("lt_c2", o2(), 8'h10);
        v2 = 0; a2 = 1; b2 = 0;
        tick();
        chk("lt_stall", o2(), 8'h10);
        v2 = 1;
        tick();
        chk("lt_done", o2(), 8'h09);
        v2 = 0;
        tick();
        chk("lt_hold", o2(), 8'h01);

        // start held through SHIFT and DONE is ignored
        st2 = 1; v2 = 1; a2 = 1; b2 = 1;
        tick();
        tick();
        chk("ign_shift", o2(), 8'h10);
        a2 = 0; b2 = 1;
        tick();
        chk("ign_done", o2(), 8'h09);
        tick();
        chk("ign_after_done", o2(), 8'h01);
        st2 = 0; v2 = 0;
        tick();
        chk("ign_idle", o2(), 8'h01);

        // reset after the first transfer of A=10 B=01
        st2 = 1; v2 = 1; a2 = 1; b2 = 0;
        tick();
        st2 = 0;
        tick();
        rst2 = 1;
        tick();
        rst2 = 0;
        chk("rst_mid", o2(), 8'h00);
        a2 = 0; b2 = 1;
        tick();
        chk("rst_idle", o2(), 8'h00);
        tick();
        chk("rst_no_done", o2(), 8'h00);
        st2 = 1; v2 = 1; a2 = 0; b2 = 0;
        tick();
        st2 = 0;
        tick();
        tick();
        chk("rst_fresh_eq", o2(), 8'h0A);
        v2 = 0;
        tick();

        // WIDTH=4: A=1010 B=1011, 3-cycle stall between bits 2 and 3
        st4 = 1;
        tick();
        st4 = 0; v4 = 1; a4 = 1; b4 = 1;
        chk("w4_ready", o4(), 8'h10);
        tick();
        a4 = 0; b4 = 0;
        tick();
        v4 = 0; a4 = 1; b4 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w4_stall", o4(), 8'h10);
        end
        v4 = 1; a4 = 1; b4 = 1;
        tick();
        chk("w4_bit3", o4(), 8'h10);
        a4 = 0; b4 = 1;
        tick();
        chk("w4_done", o4(), 8'h09);
        v4 = 0;
        tick();
        chk("w4_once", o4(), 8'h01);
        tick();
        chk("w4_hold", o4(), 8'h01);

        // WIDTH=4: A=1000 B=0111
        av = 4'b1000; bv = 4'b0111;
        st4 = 1;
        tick();
        st4 = 0; v4 = 1;
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
        a4 = av[3]; b4 = bv[3];
        tick();
        chk("ee_done", o4(), 8'h0C);
        tick();
        chk("ee_noready1", o4(), 8'h04);
        tick();
        chk("ee_noready2", o4(), 8'h04);
`else
        for (int i = 3; i > 0; i--) begin
            a4 = av[i]; b4 = bv[i];
            tick();
            chk("full_shift", o4(), 8'h10);
        end
        a4 = av[0]; b4 = bv[0];
        tick();
        chk("full_done", o4(), 8'h0C);
        tick();
        chk("full_idle", o4(), 8'h04);
`endif
        v4 = 0;
        tick();

        // WIDTH=4: A=0101 B=0101 always takes 4 transfers
        av = 4'b0101; bv = 4'b0101;
        st4 = 1;
        tick();
        st4 = 0; v4 = 1;
        for (int i = 3; i > 0; i--) begin
            a4 = av[i]; b4 = bv[i];
            tick();
            chk("eq4_shift", o4(), 8'h10);
        end
        a4 = av[0]; b4 = bv[0];
        tick();
        chk("eq4_done", o4(), 8'h0A);
        v4 = 0;
        tick();
        chk("eq4_hold", o4(), 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparador_serial.md
Name: comparador_serial

Overview:
Bit-serial magnitude comparator. It is the streamed counterpart of the team's parallel 2-bit "mayor" comparator.
- Takes two unsigned operands A and B one bit pair per transfer, MSB first, over a valid/ready handshake.
- Reports A>B, A==B or A<B after the last bit.
- Sits between a serial source (shift register or UART-style front end) and control logic that needs the ordering of two words.

Parameters:
WIDTH, 2, bits per operand; legal range 1..16.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a comparison; honoured only in IDLE
in_valid  input  1  a_bit/b_bit valid this cycle
a_bit  input  1  current bit of A (MSB first)
b_bit  input  1  current bit of B (MSB first)
in_ready  output  1  block accepts a bit pair this cycle
done  output  1  one-cycle pulse: comparison finished
mayor  output  1  result A>B
igual  output  1  result A==B
menor  output  1  result A<B

Behaviour:
- Reset, sampled on clk edge, overrides everything:
  - state=IDLE, bit counter=0, internal decision=EQ.
  - in_ready=0, done=0, mayor=0, igual=0, menor=0.
- Transfer occurs on a cycle where in_valid=1 and in_ready=1.
- All outputs are registered.
- States:
  - IDLE:
    - in_ready=0.
    - start=1 → SHIFT next cycle; counter←0, decision←EQ, mayor/igual/menor←0.
  - SHIFT:
    - in_ready=1. in_valid=0 stalls indefinitely with state held.
    - On each transfer, if decision==EQ and a_bit≠b_bit: decision←GT when a_bit=1, else LT.
    - Once decided, later bits do not change the decision.
    - counter increments per transfer.
    - Transfer with counter==WIDTH-1 → DONE.
  - DONE (one cycle):
    - done=1, in_ready=0.
    - mayor/igual/menor ← GT/EQ/LT one-hot in the same cycle.
    - Next state IDLE unconditionally.
- Result outputs hold their value after DONE until the next start is accepted.
- Exactly one of mayor/igual/menor is high after any completed comparison; all three are 0 after reset and during SHIFT.
- Latency without the optional feature:
  - First in_ready=1 on the cycle after start.
  - done on the cycle after the WIDTH-th transfer.
  - Minimum start-to-done is WIDTH+1 cycles.
- start outside IDLE is ignored.
- start in the DONE cycle is also ignored; the source must wait for IDLE.
- in_valid while in_ready=0: no transfer, no state change.
- WIDTH=1: a single transfer goes straight to DONE.
- Reset mid-operation aborts the comparison: no done pulse, partial decision discarded.

Optional Feature:
Macro: COMPARADOR_SERIAL_EARLY_EXIT_EN
- Defined:
  - On the transfer that first sets decision to GT or LT, the block goes to DONE immediately.
  - in_ready drops the following cycle and the remaining bits are not consumed; the source must flush or realign them.
  - Equal operands still take all WIDTH transfers.
- Not defined: always exactly WIDTH transfers per comparison, as specified above.

Test Plan:
- WIDTH=2, reset, start, A=10 B=01 with in_valid held high → in_ready high 2 cycles, done pulse on cycle 3 after start, mayor=1 igual=0 menor=0, held until next start.
- WIDTH=2, A=11 B=11 → igual=1 after 2 transfers. Then start with A=01 B=10 → menor=1; result outputs read 0 during SHIFT.
- WIDTH=4, A=1010 B=1011 with in_valid deasserted for 3 cycles between bits 2 and 3 → no transfers during the stall, menor=1, done exactly once after the 4th transfer.
- Reset asserted after the 1st transfer of A=10 B=01 → next cycle all outputs 0, state IDLE, no done. A fresh start with A=00 B=00 → igual=1.
- start pulsed during SHIFT and during DONE → ignored; only one done per accepted start; counter unaffected.
- With COMPARADOR_SERIAL_EARLY_EXIT_EN, WIDTH=4, A=1000 B=0111 → done on the cycle after the 1st transfer, mayor=1, in_ready=0 thereafter. A=0101 B=0101 → 4 transfers, igual=1.
